// File: rtl/load_store_unit.sv
// Load/store unit between execute and a one-cycle-latency synchronous data RAM.
// Define LSU_BYTE_ENABLE_EN when the RAM honours mem_be (no read-modify-write).
module load_store_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, MERGE, WR} state_t;

    state_t            state_q, state_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              accept;
    logic              req_bad;

    function automatic logic is_bad(input logic we, input logic [2:0] f3,
                                    input logic [1:0] a);
        logic illegal;
        logic mis;
        illegal = we ? (f3 > 3'b010)
                     : (f3 == 3'b011 || f3[2:1] == 2'b11);
        mis = (f3[1:0] == 2'b01 && a[0]) ||
              (f3[1:0] == 2'b10 && a != 2'b00);
        return illegal || mis;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  a);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {a, 3'b000});
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    assign accept    = req_valid && (state_q == IDLE);
    assign req_bad   = is_bad(req_we, req_funct3, req_addr[1:0]);
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifndef LSU_BYTE_ENABLE_EN
    logic [31:0] merge_q;

    // Old word with the addressed byte/halfword lane(s) overwritten.
    function automatic logic [31:0] merge(input logic [31:0] w,
                                          input logic [31:0] d,
                                          input logic [2:0]  f3,
                                          input logic [1:0]  a);
        logic [31:0] m;
        m = w;
        if (f3 == 3'b000) begin
            for (int i = 0; i < 4; i++)
                if (2'(i) == a) m[8*i +: 8] = d[7:0];
        end else if (a[1]) begin
            m[31:16] = d[15:0];
        end else begin
            m[15:0] = d[15:0];
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            merge_q <= 32'd0;
        else if (state_q == MERGE)
            merge_q <= merge(mem_rdata, wdata_q, f3_q, addr_q[1:0]);
    end
`else
    function automatic logic [3:0] lane_be(input logic [2:0] f3,
                                           input logic [1:0] a);
        case (f3)
            3'b000:  return 4'b0001 << a;
            3'b001:  return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && !req_bad) begin
                    if (!req_we)
                        state_d = RD;
                    else if (req_funct3 == 3'b010)
                        state_d = WR;
                    else
`ifdef LSU_BYTE_ENABLE_EN
                        state_d = WR;
`else
                        state_d = RD;
`endif
                end
            end
            RD:      state_d = MERGE;
            MERGE:   state_d = we_q ? WR : IDLE;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response is registered so it appears in the first IDLE cycle after completion.
    always_comb begin
        rsp_valid_d = (accept && req_bad) ||
                      (state_q == MERGE && !we_q) ||
                      (state_q == WR);
        rsp_err_d   = accept && req_bad;
        rsp_rdata_d = 32'd0;
        if (state_q == MERGE && !we_q)
            rsp_rdata_d = load_ext(mem_rdata, f3_q, addr_q[1:0]);
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        mem_be    = 4'b0000;
        unique case (state_q)
            RD: begin
                mem_en   = 1'b1;
                mem_addr = addr_q[ADDR_W-1:2];
            end
            WR: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = addr_q[ADDR_W-1:2];
`ifdef LSU_BYTE_ENABLE_EN
                mem_be   = lane_be(f3_q, addr_q[1:0]);
                case (f3_q)
                    3'b000:  mem_wdata = {4{wdata_q[7:0]}};
                    3'b001:  mem_wdata = {2{wdata_q[15:0]}};
                    default: mem_wdata = wdata_q;
                endcase
`else
                mem_be    = 4'b1111;
                mem_wdata = (f3_q == 3'b010) ? wdata_q : merge_q;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural one-cycle-latency RAM.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    load_store_unit #(.ADDR_W(10)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

`ifdef LSU_BYTE_ENABLE_EN
    localparam int LAT_SBH = 2;
    localparam logic [3:0] SB23_BE = 4'b1000;
`else
    localparam int LAT_SBH = 4;
    localparam logic [3:0] SB23_BE = 4'b1111;
`endif

    logic [31:0] ram [0:255];
    int cyc = 0;
    int en_cnt = 0;
    int we_cnt = 0;
    logic [3:0] last_be = 4'h0;

    always @(posedge clk) begin
        cyc++;
        if (mem_en) begin
            en_cnt++;
            if (mem_we) begin
                we_cnt++;
                last_be = mem_be;
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
            mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rdata %08h err %0b at cycle %0d expected none",
                         rsp_rdata, rsp_err, cyc);
            end else begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, "_rdata"}, rsp_rdata, e.rdata);
                check({nm, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
                check({nm, "_cycle"}, cyc, e.due);
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [9:0] a, input logic [31:0] d,
                         input bit expect_rsp, input logic e_err,
                         input logic [31:0] e_rd, input int lat,
                         input string nm, output int acc);
        int n;
        exp_t e;
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept: got ready 0 expected 1 within 50 cycles", nm);
        end else if (expect_rsp) begin
            e.err = e_err; e.rdata = e_rd; e.due = cyc + lat;
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
    endtask

    task automatic drop();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
        @(negedge clk);
    endtask

    logic [2:0]  ld_f3 [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [9:0]  ld_a  [4] = '{10'h016, 10'h016, 10'h016, 10'h014};
    logic [31:0] ld_e  [4] = '{32'hFFFF_FFFF, 32'h0000_00FF,
                               32'hFFFF_80FF, 32'h0000_7F01};

    initial begin
        int acc, sw_acc, lw_acc, en0, we0;
        for (int i = 0; i < 256; i++) ram[i] = 32'd0;
        ram[5] = 32'h80FF_7F01;
        ram[8] = 32'h1122_3344;
        ram[9] = 32'h5566_7788;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = 10'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp", {rsp_rdata[30:0], rsp_err}, 32'd0);
        check("rst_mem_ctl", {26'd0, mem_en, mem_we, mem_be}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);

        for (int i = 0; i < 4; i++)
            issue(1'b0, ld_f3[i], ld_a[i], 32'd0, 1'b1, 1'b0, ld_e[i], 3,
                  $sformatf("load%0d", i), acc);
        drop();
        drain();

        issue(1'b1, 3'b000, 10'h023, 32'h0000_00AB, 1'b1, 1'b0, 32'd0,
              LAT_SBH, "sb23", acc);
        drop();
        drain();
        check("sb23_ram", ram[8], 32'hAB22_3344);
        check("sb23_be", {28'd0, last_be}, {28'd0, SB23_BE});

        issue(1'b1, 3'b010, 10'h020, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0, 2,
              "sw20", sw_acc);
        issue(1'b0, 3'b010, 10'h020, 32'd0, 1'b1, 1'b0, 32'hDEAD_BEEF, 3,
              "lw20", lw_acc);
        drop();
        drain();
        check("b2b_gap", lw_acc - sw_acc, 2);
        check("sw_be", {28'd0, last_be}, 32'hF);

        en0 = en_cnt;
        issue(1'b0, 3'b010, 10'h022, 32'd0, 1'b1, 1'b1, 32'd0, 1, "err_lw22", acc);
        issue(1'b1, 3'b001, 10'h001, 32'h1234, 1'b1, 1'b1, 32'd0, 1, "err_sh01", acc);
        issue(1'b0, 3'b011, 10'h000, 32'd0, 1'b1, 1'b1, 32'd0, 1, "err_f3", acc);
        drop();
        drain();
        check("err_no_mem_en", en_cnt - en0, 0);

`ifndef LSU_BYTE_ENABLE_EN
        issue(1'b1, 3'b000, 10'h024, 32'h0000_00CC, 1'b0, 1'b0, 32'd0, 0,
              "sb_rst", acc);
        we0 = we_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mid_mem_en", {31'd0, mem_en}, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_mid_no_wr", we_cnt - we0, 0);
        check("rst_mid_ram", ram[9], 32'h5566_7788);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1, "timeout");
    end

endmodule
